onehot_line_sequencer: RTL and testbench
========================================

Name: onehot_line_sequencer

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot line driver with an enable gate.
- Adds timed behaviour on top of plain decoding: a LEVEL mode that holds a line, a PULSE mode that drives one line for a programmed dwell, and a SCAN mode that walks every line once.
- Drives chip-select, row-select and strobe fan-out lines from a control block through a valid/ready request port.

Parameters:
- SEL_W, 3, select width; OUT_W = 2**SEL_W output lines (derived, not overridable).
- DWELL_W, 8, width of the dwell count in cycles.
- ACTIVE_LOW, 0, when 1 all output lines are inverted (inactive = 1).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ena  in  1  global enable; low aborts activity and blanks the outputs.
- mode  in  2  request mode: 00 LEVEL, 01 PULSE, 10 SCAN, 11 reserved (treated as LEVEL).
- in_valid  in  1  request valid.
- in_ready  out  1  request ready (combinational from state and ena).
- in_sel  in  SEL_W  line index (start index in SCAN).
- in_dwell  in  DWELL_W  cycles per line for PULSE/SCAN; 0 is treated as 1.
- out_line  out  OUT_W  registered one-hot lines (polarity per ACTIVE_LOW).
- out_idx  out  SEL_W  registered index of the active line.
- busy  out  1  registered; high in the PULSE and SCAN states.
- done  out  1  registered one-cycle pulse on the last active cycle of a PULSE or SCAN.

Behaviour:
- Reset (rst_n=0 at an edge) applies regardless of ena or in-flight activity:
  - state=IDLE, out_line=all inactive, out_idx=0, busy=0, done=0, counters=0.
- States and in_ready:
  - States are IDLE, LEVEL, PULSE and SCAN.
  - in_ready = ena & (state==IDLE | state==LEVEL).
- Accept = in_valid & in_ready at an edge, at cycle T.
  - mode, in_sel and in_dwell are captured at accept.
  - Input changes after accept are ignored.
- LEVEL:
  - From T+1, line in_sel is active and out_idx=in_sel; held indefinitely.
  - A new accept in LEVEL replaces the line at the next cycle with no blank gap, in any mode.
  - done is never asserted in LEVEL.
- PULSE (D = max(in_dwell,1)):
  - Line active for cycles T+1..T+D; busy=1 over the same cycles.
  - done=1 in cycle T+D.
  - In cycle T+D+1: state=IDLE, lines inactive, in_ready=1.
  - The earliest next accept is at T+D+1, so there is always at least one blank cycle between pulses.
- SCAN (D = max(in_dwell,1)):
  - Lines in_sel, in_sel+1, ... are driven modulo OUT_W, wrapping from OUT_W-1 to 0.
  - Each line is held D cycles; exactly OUT_W lines are driven, for a total of OUT_W*D cycles starting at T+1.
  - out_idx tracks the active line.
  - done=1 in the final cycle, then the block returns to IDLE as in PULSE.
- Counters:
  - Dwell counter is DWELL_W bits, counting D-1 down to 0.
  - Step counter is SEL_W+1 bits so that OUT_W steps are representable; no overflow at full width.
- ena=0 at an edge:
  - Next cycle: state=IDLE, lines inactive, busy=0, done=0, out_idx unchanged.
  - No done is issued for an aborted PULSE/SCAN.
  - in_ready=0 combinationally while ena=0.
- Simultaneous events:
  - Priority is reset > ena=0 > accept.
  - done and a new accept cannot coincide, because in_ready=0 while busy.
- ACTIVE_LOW=1: out_line is the bitwise inverse of the internal one-hot; all other outputs are unaffected.
- Exactly one line is active at any time outside IDLE (the one-hot invariant). Verification asserts this.

Decomposition:
- Shared package holds:
  - mode encodings (MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_RSVD);
  - the state enum (ST_IDLE, ST_LEVEL, ST_PULSE, ST_SCAN).
- Sub-module onehot_decoder: purely combinational, parametrised SEL_W index plus enable to OUT_W one-hot.
  - The top registers its output and applies the ACTIVE_LOW inversion.
  - The FSM and counters stay in the top.

Test Plan:
- Defaults; LEVEL accept in_sel=5 at T, then in_sel=2 at T+4 -> out_line=8'h20 from T+1, 8'h04 from T+5; done never high.
- PULSE in_sel=3, in_dwell=4 -> out_line=8'h08 for 4 cycles, done high on the 4th, then 8'h00 and in_ready=1; a valid held during busy is not accepted until then.
- PULSE in_dwell=0 -> a single active cycle coinciding with done (same as dwell=1).
- SCAN in_sel=6, in_dwell=2 -> out_idx sequence 6,6,7,7,0,0,...,5,5 (16 cycles); done on cycle 16; wrap verified.
- SCAN running, ena dropped mid-line -> next cycle lines all inactive, busy=0, no done; in_ready=0 until ena returns. Repeat with rst_n=0 mid-scan -> all reset values.
- ACTIVE_LOW=1, SEL_W=4, LEVEL in_sel=9 -> out_line=16'hFDFF; idle/reset value 16'hFFFF.

Source files
------------

// File: rtl/onehot_line_sequencer_pkg.sv
// Shared encodings for the one-hot line sequencer: request modes and FSM states.
package onehot_line_sequencer_pkg;

  // Request mode encodings carried on the mode port.
  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;  // decoded as LEVEL

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEVEL,
    ST_PULSE,
    ST_SCAN
  } state_e;

endpackage : onehot_line_sequencer_pkg

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot decoder with an enable; all zeros when disabled.
module onehot_decoder #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(2**SEL_W)-1:0] line_o
);

  // Set exactly one bit when enabled.
  always_comb begin
    line_o = '0;
    if (en_i) begin
      line_o[sel_i] = 1'b1;
    end
  end

endmodule : onehot_decoder

// File: rtl/onehot_line_sequencer.sv
// Registered one-hot line driver with LEVEL hold, timed PULSE and full-ring SCAN modes.
module onehot_line_sequencer
  import onehot_line_sequencer_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DWELL_W-1:0]    in_dwell,
  output logic [(2**SEL_W)-1:0] out_line,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned OUT_W = 2**SEL_W;
  // Lines still to be visited after the first one of a scan.
  localparam logic [SEL_W:0] StepsM1 = (SEL_W + 1)'(OUT_W - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   line_q, line_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] dwell_rl_q, dwell_rl_d;
  logic [SEL_W:0]     step_cnt_q, step_cnt_d;

  logic               accept;
  logic [DWELL_W-1:0] req_dwell_m1;

  assign in_ready = ena & ((state_q == ST_IDLE) | (state_q == ST_LEVEL));
  assign accept   = in_valid & in_ready;
  // A dwell of zero behaves as one cycle.
  assign req_dwell_m1 = (in_dwell == '0) ? '0 : in_dwell - 1'b1;

  // Next-state, counter and done logic; priority is ena low over accept over sequencing.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_rl_d  = dwell_rl_q;
    step_cnt_d  = step_cnt_q;
    done_d      = 1'b0;

    if (!ena) begin
      state_d     = ST_IDLE;
      dwell_cnt_d = '0;
      step_cnt_d  = '0;
    end else if (accept) begin
      idx_d       = in_sel;
      dwell_rl_d  = req_dwell_m1;
      dwell_cnt_d = req_dwell_m1;
      step_cnt_d  = '0;
      case (mode)
        MODE_PULSE: begin
          state_d = ST_PULSE;
          done_d  = (req_dwell_m1 == '0);
        end
        MODE_SCAN: begin
          state_d    = ST_SCAN;
          step_cnt_d = StepsM1;
          done_d     = (req_dwell_m1 == '0) && (StepsM1 == '0);
        end
        default: begin
          state_d     = ST_LEVEL;
          dwell_cnt_d = '0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_PULSE: begin
          if (dwell_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
            done_d      = (dwell_cnt_q == DWELL_W'(1));
          end
        end
        ST_SCAN: begin
          if (dwell_cnt_q == '0) begin
            if (step_cnt_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              // Index width wraps OUT_W-1 back to 0 naturally.
              idx_d       = idx_q + 1'b1;
              step_cnt_d  = step_cnt_q - 1'b1;
              dwell_cnt_d = dwell_rl_q;
              done_d      = (step_cnt_q == (SEL_W + 1)'(1)) && (dwell_rl_q == '0);
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
            done_d      = (dwell_cnt_q == DWELL_W'(1)) && (step_cnt_q == '0);
          end
        end
        ST_IDLE, ST_LEVEL: begin
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Lines for the coming cycle are decoded from the next index and next state.
  onehot_decoder #(
    .SEL_W (SEL_W)
  ) u_decoder (
    .sel_i  (idx_d),
    .en_i   (state_d != ST_IDLE),
    .line_o (line_d)
  );

  assign busy_d = (state_d == ST_PULSE) || (state_d == ST_SCAN);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_rl_q  <= '0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_rl_q  <= dwell_rl_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign out_line = line_q ^ {OUT_W{ACTIVE_LOW}};
  assign out_idx  = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : onehot_line_sequencer

// File: tb/tb_onehot_line_sequencer.sv
// Directed bench: default instance plus an ACTIVE_LOW, SEL_W=4 instance sharing controls.
module tb_onehot_line_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] mode;
  logic       in_valid;
  logic [2:0] in_sel;
  logic [3:0] in_sel4;
  logic [7:0] in_dwell;

  logic       in_ready;
  logic [7:0] out_line;
  logic [2:0] out_idx;
  logic       busy;
  logic       done;

  logic        a_in_ready;
  logic [15:0] a_out_line;
  logic [3:0]  a_out_idx;
  logic        a_busy;
  logic        a_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_line_sequencer #(
    .SEL_W      (3),
    .DWELL_W    (8),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_dwell (in_dwell),
    .out_line (out_line),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  onehot_line_sequencer #(
    .SEL_W      (4),
    .DWELL_W    (8),
    .ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_sel   (in_sel4),
    .in_dwell (in_dwell),
    .out_line (a_out_line),
    .out_idx  (a_out_idx),
    .busy     (a_busy),
    .done     (a_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-hot invariant while busy; never more than one line at any time.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($onehot0(out_line) && (!busy || $onehot(out_line))) else begin
        errors++;
        $error("FAIL onehot observed=%0h expected=one-hot", out_line);
      end
    end
  end

  initial begin
    logic [2:0] exp_idx;

    rst_n    = 1'b0;
    ena      = 1'b1;
    mode     = 2'b00;
    in_valid = 1'b0;
    in_sel   = '0;
    in_sel4  = '0;
    in_dwell = '0;
    step();
    step();
    check("rst_line", 32'(out_line), 32'h00);
    check("rst_idx", 32'(out_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("al_rst_line", 32'(a_out_line), 32'hFFFF);
    rst_n = 1'b1;
    step();

    // LEVEL sel 5 (sel 9 on the active-low instance), then sel 2 four cycles later.
    mode     = 2'b00;
    in_sel   = 3'd5;
    in_sel4  = 4'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lvl_line_t1", 32'(out_line), 32'h20);
    check("lvl_idx_t1", 32'(out_idx), 32'd5);
    check("lvl_busy_t1", 32'(busy), 32'd0);
    check("al_lvl_line", 32'(a_out_line), 32'hFDFF);
    check("al_lvl_idx", 32'(a_out_idx), 32'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lvl_hold_line", 32'(out_line), 32'h20);
      check("lvl_hold_done", 32'(done), 32'd0);
    end
    in_sel   = 3'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lvl_line_t5", 32'(out_line), 32'h04);
    check("lvl_idx_t5", 32'(out_idx), 32'd2);
    check("lvl_done_t5", 32'(done), 32'd0);

    // PULSE sel 3 dwell 4 with valid held throughout.
    mode     = 2'b01;
    in_sel   = 3'd3;
    in_dwell = 8'd4;
    in_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("pls_line", 32'(out_line), 32'h08);
      check("pls_busy", 32'(busy), 32'd1);
      check("pls_ready", 32'(in_ready), 32'd0);
      check("pls_done", 32'(done), (c == 4) ? 32'd1 : 32'd0);
    end
    step();
    check("pls_gap_line", 32'(out_line), 32'h00);
    check("pls_gap_ready", 32'(in_ready), 32'd1);
    check("pls_gap_busy", 32'(busy), 32'd0);
    check("pls_gap_done", 32'(done), 32'd0);
    step();
    in_valid = 1'b0;
    check("pls_reaccept_line", 32'(out_line), 32'h08);
    check("pls_reaccept_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("pls2_end_line", 32'(out_line), 32'h00);

    // PULSE dwell 0 behaves as dwell 1.
    in_sel   = 3'd1;
    in_dwell = 8'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("p0_line", 32'(out_line), 32'h02);
    check("p0_done", 32'(done), 32'd1);
    check("p0_busy", 32'(busy), 32'd1);
    step();
    check("p0_end_line", 32'(out_line), 32'h00);
    check("p0_end_done", 32'(done), 32'd0);
    check("p0_end_ready", 32'(in_ready), 32'd1);

    // SCAN from 6 with dwell 2: 6,6,7,7,0,0,...,5,5.
    mode     = 2'b10;
    in_sel   = 3'd6;
    in_dwell = 8'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_idx = 3'(6 + k / 2);
      check("scn_idx", 32'(out_idx), 32'(exp_idx));
      check("scn_line", 32'(out_line), 32'h1 << exp_idx);
      check("scn_busy", 32'(busy), 32'd1);
      check("scn_done", 32'(done), (k == 15) ? 32'd1 : 32'd0);
      if (k != 15) step();
    end
    step();
    check("scn_end_line", 32'(out_line), 32'h00);
    check("scn_end_busy", 32'(busy), 32'd0);
    check("scn_end_done", 32'(done), 32'd0);

    // SCAN from 2 dwell 3, ena dropped in the middle of line 3.
    in_sel   = 3'd2;
    in_dwell = 8'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("abt_pre_idx", 32'(out_idx), 32'd3);
    ena = 1'b0;
    #1;
    check("abt_ready_comb", 32'(in_ready), 32'd0);
    step();
    check("abt_line", 32'(out_line), 32'h00);
    check("abt_busy", 32'(busy), 32'd0);
    check("abt_done", 32'(done), 32'd0);
    check("abt_idx", 32'(out_idx), 32'd3);
    check("abt_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("abt_no_done", 32'(done), 32'd0);
    end
    ena = 1'b1;
    #1;
    check("abt_ready_back", 32'(in_ready), 32'd1);

    // SCAN from 4 dwell 2, reset in the middle.
    in_sel   = 3'd4;
    in_dwell = 8'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rsc_pre_idx", 32'(out_idx), 32'd6);
    rst_n = 1'b0;
    step();
    check("rsc_line", 32'(out_line), 32'h00);
    check("rsc_idx", 32'(out_idx), 32'd0);
    check("rsc_busy", 32'(busy), 32'd0);
    check("rsc_done", 32'(done), 32'd0);
    check("al_rsc_line", 32'(a_out_line), 32'hFFFF);
    check("al_rsc_idx", 32'(a_out_idx), 32'd0);
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_onehot_line_sequencer
